// File: rtl/env_pkg.sv
// Shared types and constants for the ADSR envelope generator.
package env_pkg;

  localparam int LEVEL_W = 8;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/env_tick.sv
// Free-running prescaler producing a one-cycle tick every SYS_CLK_FREQ/TICK_FREQ clocks.
module env_tick #(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int TICK_FREQ    = 1000
) (
  input  logic sys_clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV   = SYS_CLK_FREQ / TICK_FREQ;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == CNT_LAST);

endmodule

// File: rtl/env_adsr.sv
// ADSR envelope generator: synchronised gate edges plus tick-rate level updates.
// Build option ENV_EXP_RELEASE_EN selects an exponential-style release tail.
module env_adsr
  import env_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int TICK_FREQ    = 1000
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               gate,
  input  logic [LEVEL_W-1:0] attack_step,
  input  logic [LEVEL_W-1:0] decay_step,
  input  logic [LEVEL_W-1:0] sustain_level,
  input  logic [LEVEL_W-1:0] release_step,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         state,
  output logic               active
);

  logic tick;

  env_tick #(
    .SYS_CLK_FREQ(SYS_CLK_FREQ),
    .TICK_FREQ   (TICK_FREQ)
  ) u_tick (
    .sys_clk(sys_clk),
    .reset  (reset),
    .tick   (tick)
  );

  function automatic logic signed [LEVEL_W+1:0] widen(input logic [LEVEL_W-1:0] v);
    return $signed({2'b00, v});
  endfunction

  function automatic logic [LEVEL_W-1:0] clamp_level(input logic signed [LEVEL_W+1:0] v,
                                                     input logic [LEVEL_W-1:0] lo);
    if (v <= widen(lo)) return lo;
    if (v >= widen(LEVEL_MAX)) return LEVEL_MAX;
    return v[LEVEL_W-1:0];
  endfunction

  // Stage p0/p1: two-flop synchroniser; p2: previous value for edge detection.
  // vld_pN marks flops holding real gate samples so a gate already high at
  // reset release is not mistaken for a new note.
  logic gate_p0, gate_p1, gate_p2;
  logic vld_p0, vld_p1, vld_p2;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      gate_p0 <= 1'b0;
      gate_p1 <= 1'b0;
      gate_p2 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      gate_p0 <= gate;
      gate_p1 <= gate_p0;
      gate_p2 <= gate_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
    end
  end

  logic gate_rise, gate_fall;
  assign gate_rise = vld_p2 &  gate_p1 & ~gate_p2;
  assign gate_fall = vld_p2 & ~gate_p1 &  gate_p2;

  env_state_t         state_r;
  logic [LEVEL_W-1:0] level_r;
  logic [LEVEL_W-1:0] attack_lvl, decay_lvl, release_lvl, release_dec;

`ifdef ENV_EXP_RELEASE_EN
  assign release_dec = (level_r >> 3) + 8'd1;
`else
  assign release_dec = release_step;
`endif

  assign attack_lvl  = (attack_step == '0) ? LEVEL_MAX
                     : clamp_level(widen(level_r) + widen(attack_step), '0);
  assign decay_lvl   = (decay_step == '0) ? sustain_level
                     : clamp_level(widen(level_r) - widen(decay_step), sustain_level);
  assign release_lvl = (release_dec == '0) ? '0
                     : clamp_level(widen(level_r) - widen(release_dec), '0);

  // Stage boundary: envelope state, level and activity flag all registered here.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      level_r <= '0;
      active  <= 1'b0;
    end else if (gate_rise) begin
      state_r <= ATTACK;
      active  <= 1'b1;
    end else if (state_r > RELEASE) begin
      state_r <= IDLE;
      level_r <= '0;
      active  <= 1'b0;
    end else if (gate_fall && (state_r == ATTACK || state_r == DECAY || state_r == SUSTAIN)) begin
      state_r <= RELEASE;
      active  <= 1'b1;
    end else if (tick) begin
      case (state_r)
        ATTACK: begin
          level_r <= attack_lvl;
          if (attack_lvl == LEVEL_MAX) state_r <= DECAY;
        end
        DECAY: begin
          level_r <= decay_lvl;
          if (decay_lvl == sustain_level) state_r <= SUSTAIN;
        end
        SUSTAIN: begin
          level_r <= sustain_level;
        end
        RELEASE: begin
          level_r <= release_lvl;
          if (release_lvl == '0) begin
            state_r <= IDLE;
            active  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          level_r <= '0;
          active  <= 1'b0;
        end
      endcase
    end
  end

  assign level = level_r;
  assign state = state_r;

endmodule

// File: tb/tb_env_adsr.sv
// Randomised and directed bench for env_adsr against a cycle-level envelope model.
module tb_env_adsr;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       gate;
  logic [7:0] attack_step, decay_step, sustain_level, release_step;
  logic [7:0] level;
  logic [2:0] state;
  logic       active;

  env_adsr #(
    .SYS_CLK_FREQ(1000),
    .TICK_FREQ   (100)
  ) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_level(sustain_level),
    .release_step (release_step),
    .level        (level),
    .state        (state),
    .active       (active)
  );

  always #5 sys_clk = ~sys_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: state codes 0..4, level as a plain integer.
  int m_state, m_level, n;
  bit m_tick;
  bit hist[$];

  task automatic model_reset();
    m_state = 0;
    m_level = 0;
    n       = 0;
    m_tick  = 0;
    hist.delete();
  endtask

  task automatic model_edge();
    bit rise, fall;
    int a, d, s, r, nxt, dec;
    a = attack_step; d = decay_step; s = sustain_level; r = release_step;
    n++;
    hist.push_back(gate);
    rise = 0;
    fall = 0;
    // a gate change sampled at edge k acts on the state at edge k+2
    if (n >= 4) begin
      rise =  hist[n-3] && !hist[n-4];
      fall = !hist[n-3] &&  hist[n-4];
    end
    m_tick = (n % 10 == 0);
    if (rise) m_state = 1;
    else if (fall && m_state >= 1 && m_state <= 3) m_state = 4;
    else if (m_tick) begin
      case (m_state)
        1: begin
          nxt = (a == 0) ? 255 : m_level + a;
          if (nxt >= 255) begin m_level = 255; m_state = 2; end
          else m_level = nxt;
        end
        2: begin
          nxt = (d == 0) ? s : m_level - d;
          if (nxt <= s) begin m_level = s; m_state = 3; end
          else m_level = nxt;
        end
        3: m_level = s;
        4: begin
`ifdef ENV_EXP_RELEASE_EN
          dec = m_level / 8 + 1;
`else
          dec = (r == 0) ? 256 : r;
`endif
          nxt = m_level - dec;
          if (nxt <= 0) begin m_level = 0; m_state = 0; end
          else m_level = nxt;
        end
        default: m_level = 0;
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    model_edge();
    #1;
    check("level", level, m_level);
    check("state", state, m_state);
    check("active", active, m_state != 0);
  endtask

  logic [31:0] got_q[$];
  int          eq[$];

  task automatic run_ticks(input int k);
    got_q.delete();
    while (k > 0) begin
      cyc();
      if (m_tick) begin
        got_q.push_back(level);
        k--;
      end
    end
  endtask

  task automatic run_to_tick();
    do cyc(); while (!m_tick);
  endtask

  task automatic run_until_idle(input int max_ticks);
    int k = 0;
    got_q.delete();
    while (m_state != 0 && k < max_ticks) begin
      cyc();
      if (m_tick) begin
        got_q.push_back(level);
        k++;
      end
    end
    check("idle_bound", state, 0);
  endtask

  task automatic expect_seq(input string tag, input int e[$]);
    for (int i = 0; i < e.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, e[i]);
  endtask

  task automatic set_steps(input int a, input int d, input int s, input int r);
    attack_step = 8'(a); decay_step = 8'(d); sustain_level = 8'(s); release_step = 8'(r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    gate  = 1'b0;
    set_steps(64, 32, 128, 16);
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_level", level, 0);
    check("rst_state", state, 0);
    check("rst_active", active, 0);
    @(negedge sys_clk);
    reset = 1'b0;

    // Full ADSR cycle
    run_to_tick();
    gate = 1'b1;
    run_ticks(8);
    eq = '{64, 128, 192, 255, 223, 191, 159, 128};
    expect_seq("adsr_ad", eq);
    check("sustain_state", state, 3);
    gate = 1'b0;
`ifndef ENV_EXP_RELEASE_EN
    run_ticks(8);
    eq = '{112, 96, 80, 64, 48, 32, 16, 0};
    expect_seq("adsr_rel", eq);
    check("rel_idle", state, 0);
`else
    run_until_idle(60);
    eq = '{111, 97, 84};
    expect_seq("exp_rel", eq);
`endif
    check("rel_active", active, 0);

    // Retrigger during release keeps the current level
    run_to_tick();
    gate = 1'b1;
    run_ticks(8);
    gate = 1'b0;
    run_ticks(3);
`ifndef ENV_EXP_RELEASE_EN
    eq = '{112, 96, 80};
`else
    eq = '{111, 97, 84};
`endif
    expect_seq("retrig_rel", eq);
    gate = 1'b1;
    run_ticks(1);
`ifndef ENV_EXP_RELEASE_EN
    eq = '{144};
`else
    eq = '{148};
`endif
    expect_seq("retrig_att", eq);
    check("retrig_state", state, 1);
    run_ticks(6);
    gate = 1'b0;
    run_until_idle(60);

    // Zero-step boundaries
    set_steps(0, 0, 200, 0);
    run_to_tick();
    gate = 1'b1;
    run_ticks(2);
    eq = '{255, 200};
    expect_seq("zero_step", eq);
    check("zero_sustain", state, 3);
    gate = 1'b0;
`ifndef ENV_EXP_RELEASE_EN
    run_ticks(1);
    eq = '{0};
    expect_seq("zero_rel", eq);
    check("zero_idle", state, 0);
`else
    run_until_idle(60);
`endif

    // Gate edge landing on a tick cycle
    set_steps(64, 32, 128, 16);
    run_to_tick();
    gate = 1'b1;
    run_ticks(8);
    gate = 1'b0;
    run_ticks(2);
    repeat (7) cyc();
    gate = 1'b1;
    repeat (3) cyc();
    check("coll_state", state, 1);
`ifndef ENV_EXP_RELEASE_EN
    check("coll_level", level, 96);
    run_ticks(1);
    eq = '{160};
`else
    check("coll_level", level, 97);
    run_ticks(1);
    eq = '{161};
`endif
    expect_seq("coll_next", eq);
    gate = 1'b0;
    run_until_idle(60);

    // Async reset mid-attack, gate held high afterwards
    set_steps(40, 32, 128, 16);
    run_to_tick();
    gate = 1'b1;
    run_ticks(3);
    eq = '{40, 80, 120};
    expect_seq("pre_reset", eq);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_level", level, 0);
    check("midrst_state", state, 0);
    check("midrst_active", active, 0);
    model_reset();
    #1;
    reset = 1'b0;
    repeat (40) cyc();
    check("hold_idle", state, 0);

    // Randomised gate activity and step settings
    gate = 1'b0;
    repeat (4000) begin
      if ($urandom_range(0, 79) == 0) gate = ~gate;
      if ($urandom_range(0, 149) == 0)
        set_steps(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                  $urandom_range(0, 255),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
